// File: rtl/sar_search_controller_pkg.sv
// Shared arithmetic-library definitions: SAR controller state encoding and
// the comparator flag validity check.
package arith_pkg;

    localparam logic [1:0] STATE_IDLE    = 2'd0;
    localparam logic [1:0] STATE_COMPARE = 2'd1;
    localparam logic [1:0] STATE_DONE    = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = STATE_IDLE,
        ST_COMPARE = STATE_COMPARE,
        ST_DONE    = STATE_DONE
    } sar_state_t;

    // Flag vector ordering is {greater, equal, less}.
    localparam int FLAG_LT = 0;
    localparam int FLAG_EQ = 1;
    localparam int FLAG_GT = 2;

    // Unknown flag bits make the result unknown, which callers must treat as
    // "not one-hot" by testing the true branch only.
    function automatic logic flags_one_hot(input logic [2:0] flags);
        return (flags == 3'b001) || (flags == 3'b010) || (flags == 3'b100);
    endfunction

endpackage

// File: rtl/sar_search_controller.sv
// Successive-approximation search: drives trial words into an external
// magnitude comparator and recovers the comparator's A-side value bit by bit.
module sar_search_controller
    import arith_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  Clock_In,
    input  logic                  Reset_In,
    input  logic                  Start_In,
    input  logic                  Target_Less_Than_Trial_In,
    input  logic                  Target_Equal_To_Trial_In,
    input  logic                  Target_Greater_Than_Trial_In,
    output logic [DATA_WIDTH-1:0] Trial_Data_Out,
    output logic [DATA_WIDTH-1:0] Result_Out,
    output logic                  Busy_Out,
    output logic                  Done_Out,
    output logic                  Error_Out
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0]      TOP_IDX     = IDX_W'(DATA_WIDTH - 1);
    localparam logic [DATA_WIDTH-1:0] FIRST_TRIAL = DATA_WIDTH'(1) << (DATA_WIDTH - 1);

    sar_state_t            state_reg;
    logic [DATA_WIDTH-1:0] trial_reg;
    logic [DATA_WIDTH-1:0] result_reg;
    logic [IDX_W-1:0]      bit_idx_reg;
    logic                  done_reg;
    logic                  error_reg;

    logic [2:0]            flags;
    logic [DATA_WIDTH-1:0] adjusted_trial;
    logic [DATA_WIDTH-1:0] trial_next;

    assign flags = {Target_Greater_Than_Trial_In,
                    Target_Equal_To_Trial_In,
                    Target_Less_Than_Trial_In};

    // Bit k is cleared on LT and kept otherwise; the next lower bit is then
    // raised as the following guess. Pure bit set/clear, no carries.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_WIDTH; gi = gi + 1) begin : g_trial_bits
            assign adjusted_trial[gi] = (bit_idx_reg == IDX_W'(gi))
                                      ? (trial_reg[gi] & ~flags[FLAG_LT])
                                      : trial_reg[gi];
            if (gi < DATA_WIDTH - 1) begin : g_guess
                assign trial_next[gi] = (bit_idx_reg == IDX_W'(gi + 1)) | adjusted_trial[gi];
            end else begin : g_msb
                assign trial_next[gi] = adjusted_trial[gi];
            end
        end
    endgenerate

    always_ff @(posedge Clock_In) begin
        if (Reset_In) begin
            state_reg   <= ST_IDLE;
            trial_reg   <= '0;
            result_reg  <= '0;
            bit_idx_reg <= '0;
            done_reg    <= 1'b0;
            error_reg   <= 1'b0;
        end else begin
            done_reg  <= 1'b0;
            error_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (Start_In) begin
                        state_reg   <= ST_COMPARE;
                        trial_reg   <= FIRST_TRIAL;
                        bit_idx_reg <= TOP_IDX;
                        result_reg  <= '0;
                    end
                end
                ST_COMPARE: begin
                    if (flags_one_hot(flags)) begin
                        if (flags[FLAG_EQ]) begin
                            result_reg <= trial_reg;
                            state_reg  <= ST_DONE;
                            done_reg   <= 1'b1;
                        end else if (bit_idx_reg == '0) begin
                            result_reg <= adjusted_trial;
                            trial_reg  <= adjusted_trial;
                            state_reg  <= ST_DONE;
                            done_reg   <= 1'b1;
                        end else begin
                            trial_reg   <= trial_next;
                            bit_idx_reg <= bit_idx_reg - IDX_W'(1);
                        end
                    end else begin
                        result_reg <= '0;
                        trial_reg  <= '0;
                        state_reg  <= ST_DONE;
                        done_reg   <= 1'b1;
                        error_reg  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign Trial_Data_Out = trial_reg;
    assign Result_Out     = result_reg;
    assign Busy_Out       = (state_reg == ST_COMPARE);
    assign Done_Out       = done_reg;
    assign Error_Out      = error_reg;

endmodule

// File: tb/tb_sar_search_controller.sv
// Directed and randomized bench for sar_search_controller with a behavioural
// comparator and an arithmetic reference of the expected trial sequence.
module tb_sar_search_controller;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         srst;
    logic         start;
    logic [W-1:0] target;
    logic         force_en;
    logic [2:0]   force_flags;
    logic         lt, eq, gt;
    logic [W-1:0] trial, result;
    logic         busy, done, error;

    int checks   = 0;
    int failures = 0;
    int exp_trials[$];
    int exp_result;

    sar_search_controller #(.DATA_WIDTH(W)) dut (
        .Clock_In                     (clk),
        .Reset_In                     (srst),
        .Start_In                     (start),
        .Target_Less_Than_Trial_In    (lt),
        .Target_Equal_To_Trial_In     (eq),
        .Target_Greater_Than_Trial_In (gt),
        .Trial_Data_Out               (trial),
        .Result_Out                   (result),
        .Busy_Out                     (busy),
        .Done_Out                     (done),
        .Error_Out                    (error)
    );

    always #5 clk = ~clk;

    // Behavioural comparator, with an override for injecting bad flag patterns.
    always_comb begin
        lt = 1'b0;
        eq = 1'b0;
        gt = 1'b0;
        if (force_en) begin
            {gt, eq, lt} = force_flags;
        end else begin
            lt = (target < trial);
            eq = (target == trial);
            gt = (target > trial);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Binary search as arithmetic: at bit k the guess keeps the target's bits
    // above k, sets bit k and zeroes everything below; it stops on equality.
    function automatic void build_expected(input int tgt);
        int t;
        exp_trials.delete();
        for (int k = W - 1; k >= 0; k--) begin
            t = ((tgt >> (k + 1)) << (k + 1)) | (1 << k);
            exp_trials.push_back(t);
            if (t == tgt) break;
        end
        exp_result = tgt;
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge of the
    // idle cycle that follows DONE.
    task automatic run_search(input logic [W-1:0] tgt, input bit hold, input bit jitter);
        int cycles;
        int idx;
        target = tgt;
        build_expected(int'(tgt));
        start = 1'b1;
        @(negedge clk);
        if (!hold) start = jitter ? 1'($urandom_range(0, 1)) : 1'b0;
        cycles = 1;
        idx    = 0;
        while (done !== 1'b1 && cycles <= W + 2) begin
            check("busy_compare", busy, 1);
            if (idx < exp_trials.size())
                check("trial", trial, exp_trials[idx]);
            else
                check("extra_compare", idx, exp_trials.size());
            idx++;
            @(negedge clk);
            cycles++;
            if (!hold && jitter) start = 1'($urandom_range(0, 1));
        end
        if (!hold) start = 1'b0;
        check("done_seen", done, 1);
        check("latency", cycles, exp_trials.size() + 1);
        check("result", result, exp_result);
        check("error_clear", error, 0);
        check("busy_done", busy, 0);
        $display("search target=%02h compares=%0d latency=%0d result=%02h hold=%0d",
                 tgt, idx, cycles, result, hold);
        @(negedge clk);
        check("done_width", done, 0);
        check("busy_idle", busy, 0);
        check("result_hold", result, exp_result);
    endtask

    task automatic run_error(input logic [2:0] bad, input int after);
        target = '0;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (after) @(negedge clk);
        check("busy_before_err", busy, 1);
        force_en    = 1'b1;
        force_flags = bad;
        @(negedge clk);
        force_en = 1'b0;
        check("err_done", done, 1);
        check("err_error", error, 1);
        check("err_result", result, 0);
        check("err_trial", trial, 0);
        check("err_busy", busy, 0);
        $display("error flags=%03b after=%0d done=%0d error=%0d", bad, after, done, error);
        @(negedge clk);
        check("err_done_width", done, 0);
        check("err_error_width", error, 0);
    endtask

    initial begin
        srst        = 1'b1;
        start       = 1'b0;
        target      = '0;
        force_en    = 1'b0;
        force_flags = 3'b000;
        repeat (3) @(negedge clk);
        check("rst_trial", trial, 0);
        check("rst_result", result, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        srst = 1'b0;
        @(negedge clk);

        run_search(8'h5A, 1'b0, 1'b0);
        run_search(8'h00, 1'b0, 1'b0);
        run_search(8'hFF, 1'b0, 1'b0);
        run_search(8'h80, 1'b0, 1'b0);
        run_search(8'h01, 1'b0, 1'b0);

        run_error(3'b000, 2);
        run_search(8'h3C, 1'b0, 1'b0);
        run_error(3'b110, 4);
        run_search(8'hC3, 1'b0, 1'b0);
        run_error(3'b111, 0);

        // Reset on the third compare cycle, with start also high.
        target = 8'h00;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("busy_before_rst", busy, 1);
        srst  = 1'b1;
        start = 1'b1;
        @(negedge clk);
        check("midrst_trial", trial, 0);
        check("midrst_result", result, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_error", error, 0);
        $display("reset mid-search trial=%02h busy=%0d done=%0d", trial, busy, done);
        srst  = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("postrst_done", done, 0);
        check("postrst_busy", busy, 0);
        run_search(8'h77, 1'b0, 1'b0);

        for (int i = 0; i < 16; i++)
            run_search(W'($urandom), 1'b0, 1'b1);

        for (int i = 0; i < 6; i++)
            run_search(W'($urandom), 1'b1, 1'b0);
        start = 1'b0;
        run_search(8'hA5, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sar_search_controller.md
# sar_search_controller

Successive-approximation search engine that drives the B side of a magnitude comparator and uses its three relational flags to recover an unknown W-bit value on the comparator's A side. It is the driving end of the comparator interface: it produces trial words and consumes less/equal/greater results. It sits beside any `Comparator_*` instance in the arithmetic library. Typical uses are threshold search, digital SAR-ADC control and bench self-checks.

## Interface
- `DATA_WIDTH`, default 8: width of the trial, target and result words. Must be at least 1.
- `Clock_In` input, 1 bit: single clock; all state changes on the rising edge.
- `Reset_In` input, 1 bit: synchronous, active-high reset.
- `Start_In` input, 1 bit: begins a search when sampled high in IDLE.
- `Target_Less_Than_Trial_In` input, 1 bit: comparator A < B flag.
- `Target_Equal_To_Trial_In` input, 1 bit: comparator A = B flag.
- `Target_Greater_Than_Trial_In` input, 1 bit: comparator A > B flag.
- `Trial_Data_Out` output, DATA_WIDTH bits: registered trial word that drives the comparator B input.
- `Result_Out` output, DATA_WIDTH bits: recovered value, held until the next accepted start.
- `Busy_Out` output, 1 bit: high while in COMPARE.
- `Done_Out` output, 1 bit: one-cycle pulse when a search ends, whether it succeeds or errors.
- `Error_Out` output, 1 bit: one-cycle pulse, coincident with `Done_Out`, when the flags were not one-hot.

## Operation
- The comparator path is combinational. Flags are sampled at the edge after `Trial_Data_Out` changes.
- **States:**
  - IDLE: waiting for a start.
  - COMPARE: one bit decision per cycle.
  - DONE: one cycle, then back to IDLE.
- **IDLE to COMPARE** on `Start_In`=1:
  - `Trial_Data_Out` is set to 1 << (W-1).
  - Bit index k is set to W-1.
  - `Result_Out` is cleared to 0.
- **Each COMPARE cycle**, using the sampled flags:
  - Flags not exactly one-hot (none set, or more than one set, including Z/X resolving to that): go to DONE and pulse `Error_Out`. `Result_Out` is 0, `Trial_Data_Out` is 0.
  - EQ: `Result_Out` is set to the current trial. Go to DONE early.
  - GT: bit k is kept.
  - LT: bit k is cleared.
  - If k = 0: `Result_Out` is set to the adjusted trial. Go to DONE.
  - Otherwise: set bit k-1 in the trial and decrement k.
- **DONE:**
  - `Done_Out`=1 for exactly this cycle.
  - `Busy_Out`=0.
  - Next state is IDLE.
- `Start_In` is ignored in COMPARE and DONE. It is not queued.
- Arithmetic is pure bit set/clear; there is no addition and no wrap-around. Trial and result always stay within [0, 2^W - 1].
- GT at k = 0 is accepted and keeps the bit. The bench treats it as a comparator fault, not a controller error.

## Timing
- **Reset values:** state IDLE; `Trial_Data_Out`=0, `Result_Out`=0, `Busy_Out`=0, `Done_Out`=0, `Error_Out`=0.
- **Reset mid-search:** the search aborts on the next edge. No `Done_Out`, no `Error_Out`. Reset has priority over `Start_In`.
- **Start to first trial:** the first trial is visible one cycle after `Start_In` is sampled.
- **Latency** from the `Start_In` edge to the `Done_Out` cycle:
  - j+1 cycles if EQ occurs on the j-th compare.
  - W+1 cycles worst case.
  - 2 cycles minimum (EQ on the first compare).
- **Back-to-back searches:** the earliest restart is the cycle after DONE, so the period is latency+1.
- **Result stability:** `Result_Out` is valid from the `Done_Out` cycle and stable until the next accepted start.

## Structure
- A shared package `arith_pkg` holds:
  - state encoding localparams (IDLE=2'd0, COMPARE=2'd1, DONE=2'd2);
  - the flag one-hot check as a function.
- No sub-module. The comparator is instantiated externally, beside this block, never inside it.
- Single always block for state, trial, k and result registers. Combinational decode for `Busy_Out`.

## Test plan
- **W=8, behavioral comparator, target 0x5A, pulse start:** trials 0x80, 0x40, 0x60, 0x50, 0x58, 0x5C, 0x5A. EQ on compare 7, `Done_Out` 8 cycles after start, `Result_Out`=0x5A.
- **W=8, targets 0x00 and 0xFF:**
  - 0x00: trials 0x80 down to 0x01, all LT, `Result_Out`=0x00 after 9 cycles.
  - 0xFF: all GT up to trial 0xFF, EQ on compare 8, `Result_Out`=0xFF.
- **W=2, real `Comparator_2_Bit`, target 2'b01:** trials 2'b10 then 2'b01 (EQ), `Result_Out`=2'b01 in 3 cycles. Exhaustive sweep of targets 0-3 all match.
- **Flags forced to 3'b000, then 3'b110, during compare:** `Error_Out` and `Done_Out` pulse together, `Result_Out`=0. Next start runs normally.
- **`Reset_In` raised on the 3rd compare cycle:** all outputs 0 next cycle, no `Done_Out`. A start after release gives the correct result.
- **`Start_In` held high throughout:** back-to-back searches with one DONE and one IDLE cycle between them. Mid-search `Start_In` pulses do not alter the trial sequence.
